trace_event_collector: RTL and testbench
========================================

Name: trace_event_collector

Overview:
- Sits directly downstream of the per-instance toggle generators. Each generator drives one bit that changes on clock activity.
- Samples all INSTANCES bits every cycle, detects value changes and timestamps them.
- Serialises the events, lowest index first, through a FIFO to a single valid/ready consumer (display/trace sink).
- Bursts of simultaneous changes are absorbed. A per-instance repeat change while an event is still pending is coalesced, never dropped.

Parameters:
- INSTANCES, 10, number of monitored input bits (1..64).
- DEPTH, 8, event FIFO depth (power of two, >=2).
- TS_W, 16, timestamp counter width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset, synchronous and active-high.
- sig_in  input  INSTANCES  monitored bits, one per instance.
- out_valid  output  1  head event available.
- out_ready  input  1  consumer accepts head event when high with out_valid.
- out_idx  output  $clog2(INSTANCES) (min 1)  instance index of the head event.
- out_value  output  1  new value of that instance.
- out_time  output  TS_W  timestamp of first detection.
- busy  output  1  any pending bit set or FIFO non-empty.
- coalesce_cnt  output  16  coalesced-change counter (see Optional Feature).

Behaviour:
- Reset (a rst=1 edge):
  - cur and prev are loaded from sig_in, so no spurious events follow reset.
  - pending, FIFO, ts_cnt and coalesce_cnt all clear.
  - Outputs after the edge: out_valid=0, out_idx=0, out_value=0, out_time=0, busy=0, coalesce_cnt=0.
  - Reset mid-operation discards all queued and pending events. rst overrides a simultaneous handshake.
- Edge numbering: edge 0 is the first edge with rst=0.
- ts_cnt: increments by 1 every non-reset edge and wraps modulo 2^TS_W. After edge E it holds E+1.
- Sampling pipeline: every edge, cur<=sig_in and prev<=cur.
  - chg[i] = cur[i]^prev[i] (combinational).
- Detection, on chg[i]:
  - If pending[i]=0: pending[i]<=1 and ts[i]<=ts_cnt.
  - If pending[i]=1 and the bit is not being pushed this cycle: pending[i] stays 1, ts[i] is kept, and the coalesce counter increments.
- Arbiter:
  - Each cycle, selects the lowest i with pending[i]=1.
  - Pushes {i, prev[i], ts[i]} into the FIFO when push is allowed, then clears pending[i].
  - At most one push per cycle.
- Set beats clear: if chg[i] occurs on the same edge that i is pushed, pending[i] stays 1 with ts[i]<=ts_cnt. This is a new event, not a coalesce.
- Value semantics:
  - out_value is the latest sampled value at push time.
  - A double toggle while pending therefore reports the original value, with one event and coalesce_cnt+1.
- Latency: a change of sig_in sampled at edge E gives out_valid=1 after edge E+2 (empty FIFO, no higher-priority pending), with out_time=E+1.
- FIFO:
  - First-word fall-through; the head is presented registered.
  - Pop on out_valid&&out_ready.
  - Push is allowed when not full, or when full and a pop occurs the same cycle.
  - When full with no pop, no push; pending bits hold and the arbiter retries each cycle.
  - Pointers wrap modulo DEPTH. Count ranges 0..DEPTH.
- Empty FIFO: out_valid=0, and out_idx/out_value/out_time hold their last values. The sink must ignore them.
- out_valid deasserts only by pop or reset. The head remains stable while out_valid=1 and out_ready=0.
- Coalesce counter is saturating at 16'hFFFF.

Optional Feature:
- Macro TRACE_COLLECT_COALESCE_CNT_EN.
- Defined: coalesce_cnt counts coalesced changes as specified, saturating, and clears on reset.
- Undefined: the counter logic is not built and coalesce_cnt is tied to 0. Event stream behaviour is identical in both builds.

Test Plan:
- Single toggle: after reset with sig_in=0, set sig_in[3]=1 before edge 5 -> after edge 7: out_valid=1, out_idx=3, out_value=1, out_time=6. With out_ready=1, out_valid=0 after edge 8.
- Simultaneous burst: flip sig_in[9], [0] and [4] together before edge 10 -> events delivered in order idx 0, 4, 9, all with out_time=11. busy=0 after the last pop.
- Backpressure/full: out_ready=0, DEPTH=8, toggle all 10 bits once -> FIFO holds idx 0..7 and pending keeps 8 and 9. Then raise out_ready -> 10 events in index order, none lost, and pushes of 8 and 9 proceed on pop cycles.
- Coalesce: out_ready=0 and FIFO full, toggle sig_in[9] twice while it is pending -> one event for idx 9 with out_value equal to the original value. coalesce_cnt=1 with TRACE_COLLECT_COALESCE_CNT_EN, 0 without.
- Reset mid-operation: with 5 events queued, assert rst for one edge -> out_valid=0, busy=0, coalesce_cnt=0 after that edge. No events emerge with sig_in held static.
- Timestamp wrap: TS_W=4, toggle sig_in[1] before edge 15 -> out_time=0.

Source files
------------

// File: rtl/trace_event_collector_if.sv
// rtl/trace_event_collector_if.sv - event output handshake between collector and trace sink
interface trace_event_collector_if #(
    parameter int IDX_W = 4,
    parameter int TS_W  = 16
) ();
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_value;
    logic [TS_W-1:0]  out_time;

    modport master (
        output out_valid,
        output out_idx,
        output out_value,
        output out_time,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_idx,
        input  out_value,
        input  out_time,
        output out_ready
    );
endinterface

// File: rtl/trace_event_collector.sv
// rtl/trace_event_collector.sv - change detector, timestamping and FIFO serialiser; option macro TRACE_COLLECT_COALESCE_CNT_EN
module trace_event_collector #(
    parameter  int INSTANCES = 10,
    parameter  int DEPTH     = 8,
    parameter  int TS_W      = 16,
    localparam int IDX_W     = (INSTANCES > 1) ? $clog2(INSTANCES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [INSTANCES-1:0]     sig_in,
    trace_event_collector_if.master  ev,
    output logic                     busy,
    output logic [15:0]              coalesce_cnt
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int E_W   = IDX_W + 1 + TS_W;

    logic [INSTANCES-1:0] cur;
    logic [INSTANCES-1:0] prev;
    logic [INSTANCES-1:0] chg;
    logic [INSTANCES-1:0] pending;
    logic [TS_W-1:0]      ts [INSTANCES];
    logic [TS_W-1:0]      ts_cnt;

    logic [E_W-1:0]       mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]     count;
    logic [E_W-1:0]       head;

    logic [IDX_W-1:0]     sel;
    logic                 any_pending;
    logic                 full;
    logic                 pop;
    logic                 push;
    logic [E_W-1:0]       push_data;

    assign chg = cur ^ prev;

    // Two-stage sampling; reset loads both stages so nothing fires after reset
    always_ff @(posedge clk) begin
        if (rst) begin
            cur  <= sig_in;
            prev <= sig_in;
        end else begin
            cur  <= sig_in;
            prev <= cur;
        end
    end

    // Free-running timestamp, wraps naturally at 2^TS_W
    always_ff @(posedge clk) begin
        if (rst) ts_cnt <= '0;
        else     ts_cnt <= ts_cnt + 1'b1;
    end

    // Fixed-priority arbiter: lowest pending index wins, one push per cycle
    always_comb begin
        sel         = '0;
        any_pending = 1'b0;
        for (int i = INSTANCES - 1; i >= 0; i--) begin
            if (pending[i]) begin
                sel         = IDX_W'(i);
                any_pending = 1'b1;
            end
        end
        full      = (count == CNT_W'(DEPTH));
        pop       = ev.out_valid && ev.out_ready;
        push      = any_pending && (!full || pop);
        push_data = {sel, prev[sel], ts[sel]};
    end

    // Pending bits and first-detection timestamps; a new change wins over the push clear
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < INSTANCES; i++) ts[i] <= '0;
        end else begin
            for (int i = 0; i < INSTANCES; i++) begin
                if (chg[i]) begin
                    pending[i] <= 1'b1;
                    if (!pending[i] || (push && sel == IDX_W'(i))) ts[i] <= ts_cnt;
                end else if (push && sel == IDX_W'(i)) begin
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Event storage, written on push; no reset needed for the data array
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    // FIFO pointers, occupancy and registered head (holds last value while empty)
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (push && (count == '0 || (pop && count == CNT_W'(1))))
                head <= push_data;
            else if (pop && count > CNT_W'(1))
                head <= mem[rd_ptr + 1'b1];
        end
    end

    assign ev.out_valid = (count != '0);
    assign {ev.out_idx, ev.out_value, ev.out_time} = head;
    assign busy = (|pending) || (count != '0);

`ifdef TRACE_COLLECT_COALESCE_CNT_EN
    logic [INSTANCES-1:0] push_mask;
    logic [INSTANCES-1:0] coal_hits;
    logic [6:0]           coal_n;
    logic [16:0]          coal_sum;
    logic [15:0]          coal_q;

    // Count changes that land on an already-pending bit not leaving this cycle
    always_comb begin
        push_mask = push ? (INSTANCES'(1) << sel) : '0;
        coal_hits = chg & pending & ~push_mask;
        coal_n    = '0;
        for (int i = 0; i < INSTANCES; i++) coal_n = coal_n + 7'(coal_hits[i]);
        coal_sum  = {1'b0, coal_q} + 17'(coal_n);
    end

    // Saturating coalesce counter
    always_ff @(posedge clk) begin
        if (rst)              coal_q <= '0;
        else if (coal_sum[16]) coal_q <= 16'hFFFF;
        else                  coal_q <= coal_sum[15:0];
    end

    assign coalesce_cnt = coal_q;
`else
    assign coalesce_cnt = '0;
`endif
endmodule

// File: tb/tb_trace_event_collector.sv
// tb/tb_trace_event_collector.sv - scoreboard bench for trace_event_collector
module tb_trace_event_collector;
    localparam int N  = 10;
    localparam int D  = 8;
    localparam int IW = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] sig_in = '0;
    logic         rdy = 1'b1;
    logic         busy16, busy4;
    logic [15:0]  cc16, cc4;
    logic         mon_en = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    trace_event_collector_if #(.IDX_W(IW), .TS_W(16)) ev16 ();
    trace_event_collector_if #(.IDX_W(IW), .TS_W(4))  ev4 ();

    assign ev16.out_ready = rdy;
    assign ev4.out_ready  = rdy;

    trace_event_collector #(.INSTANCES(N), .DEPTH(D), .TS_W(16)) dut16 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .ev(ev16), .busy(busy16), .coalesce_cnt(cc16)
    );
    trace_event_collector #(.INSTANCES(N), .DEPTH(D), .TS_W(4)) dut4 (
        .clk(clk), .rst(rst), .sig_in(sig_in), .ev(ev4), .busy(busy4), .coalesce_cnt(cc4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        int          idx;
        bit          val;
        int unsigned ts;
    } ev_t;

    ev_t          mq[$];
    bit [N-1:0]   m_cur, m_prev, m_pend, m_chg;
    int unsigned  m_ts[N];
    int unsigned  m_tscnt;
    int           m_coal;
    int           m_sel;
    bit           m_pop, m_push;

    // Reference model: queue of events, pending flags with first-seen times
    always @(posedge clk) begin
        if (rst) begin
            m_cur   = sig_in;
            m_prev  = sig_in;
            m_pend  = '0;
            mq.delete();
            m_tscnt = 0;
            m_coal  = 0;
        end else begin
            m_chg = m_cur ^ m_prev;
            m_pop = (mq.size() != 0) && rdy;
            m_sel = -1;
            for (int i = 0; i < N; i++)
                if (m_pend[i] && m_sel < 0) m_sel = i;
            m_push = (m_sel >= 0) && (mq.size() < D || m_pop);
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                mq.push_back('{m_sel, m_prev[m_sel], m_ts[m_sel]});
                m_pend[m_sel] = 1'b0;
            end
            for (int i = 0; i < N; i++) begin
                if (m_chg[i]) begin
                    if (m_pend[i]) begin
                        if (m_coal < 65535) m_coal++;
                    end else begin
                        m_pend[i] = 1'b1;
                        m_ts[i]   = m_tscnt;
                    end
                end
            end
            m_prev  = m_cur;
            m_cur   = sig_in;
            m_tscnt = m_tscnt + 1;
        end
    end

    // Monitor: compare both DUTs against the model away from the active edge
    always @(negedge clk) begin
        if (mon_en) begin
            int exp_cc;
`ifdef TRACE_COLLECT_COALESCE_CNT_EN
            exp_cc = m_coal;
`else
            exp_cc = 0;
`endif
            chk("valid16", ev16.out_valid, mq.size() != 0);
            chk("valid4",  ev4.out_valid,  mq.size() != 0);
            if (mq.size() != 0) begin
                chk("idx16",   ev16.out_idx,   mq[0].idx);
                chk("idx4",    ev4.out_idx,    mq[0].idx);
                chk("value16", ev16.out_value, mq[0].val);
                chk("value4",  ev4.out_value,  mq[0].val);
                chk("time16",  ev16.out_time,  mq[0].ts & 32'hFFFF);
                chk("time4",   ev4.out_time,   mq[0].ts & 32'hF);
            end
            chk("busy16", busy16, (m_pend != '0) || (mq.size() != 0));
            chk("busy4",  busy4,  (m_pend != '0) || (mq.size() != 0));
            chk("coal16", cc16, exp_cc);
            chk("coal4",  cc4,  exp_cc);
        end
    end

    initial begin
        int k;
        repeat (2) @(negedge clk);
        chk("rst_idx",   ev16.out_idx, 0);
        chk("rst_value", ev16.out_value, 0);
        chk("rst_time",  ev16.out_time, 0);
        chk("rst_valid", ev16.out_valid, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // single toggle: change seen at edge 5
        repeat (5) @(negedge clk);
        sig_in[3] = 1'b1;
        repeat (3) @(negedge clk);
        chk("single_valid", ev16.out_valid, 1);
        chk("single_idx",   ev16.out_idx, 3);
        chk("single_value", ev16.out_value, 1);
        chk("single_time",  ev16.out_time, 6);
        @(negedge clk);
        chk("single_pop", ev16.out_valid, 0);

        // simultaneous burst before edge 10
        @(negedge clk);
        sig_in[9] = ~sig_in[9];
        sig_in[0] = ~sig_in[0];
        sig_in[4] = ~sig_in[4];
        repeat (3) @(negedge clk);
        chk("burst_time", ev16.out_time, 11);
        repeat (10) @(negedge clk);
        chk("burst_idle", busy16, 0);

        // backpressure, then coalesce on a still-pending bit
        rdy    = 1'b0;
        sig_in = ~sig_in;
        repeat (15) @(negedge clk);
        sig_in[9] = ~sig_in[9];
        @(negedge clk);
        sig_in[9] = ~sig_in[9];
        repeat (5) @(negedge clk);
        rdy = 1'b1;
        repeat (25) @(negedge clk);

        // reset mid-operation with events queued
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) sig_in[i] = ~sig_in[i];
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_valid", ev16.out_valid, 0);
        chk("mid_rst_busy",  busy16, 0);
        rdy = 1'b1;
        repeat (10) @(negedge clk);

        // randomized traffic with occasional reset
        for (int c = 0; c < 4000; c++) begin
            rdy = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, N - 1);
                sig_in[k] = ~sig_in[k];
            end
            if ($urandom_range(0, 9) == 0) begin
                k = $urandom_range(0, N - 1);
                sig_in[k] = ~sig_in[k];
            end
            rst = ($urandom_range(0, 599) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        rdy = 1'b1;
        repeat (40) @(negedge clk);
        chk("drain_busy", busy16, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
